// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back arbiter and pending-write scoreboard
module regfile_wb_arbiter #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    alu_valid,
    input  logic [REG_ADDR_W-1:0]   alu_rd,
    input  logic [DATA_W-1:0]       alu_data,
    output logic                    alu_ready,
    input  logic                    ld_valid,
    input  logic [REG_ADDR_W-1:0]   ld_rd,
    input  logic [DATA_W-1:0]       ld_data,
    output logic                    ld_ready,
    input  logic                    mul_valid,
    input  logic [REG_ADDR_W-1:0]   mul_rd,
    input  logic [DATA_W-1:0]       mul_data,
    output logic                    mul_ready,
    input  logic                    iss_valid,
    input  logic [REG_ADDR_W-1:0]   iss_rd,
    output logic                    iss_ready,
    output logic                    Write_enable,
    output logic [REG_ADDR_W-1:0]   Write_reg,
    output logic [DATA_W-1:0]       Write_data,
    output logic [(1<<REG_ADDR_W)-1:0] busy
);

    localparam int NREG = 1 << REG_ADDR_W;

    // Source indices: 0=ALU, 1=LD, 2=MUL
    logic [1:0]            r_rr;
    logic                  r_we;
    logic [REG_ADDR_W-1:0] r_wreg;
    logic [DATA_W-1:0]     r_wdata;
    logic [NREG-1:0]       r_busy;

    logic [2:0]            w_valid;
    logic [1:0]            w_o0, w_o1, w_o2;
    logic [2:0]            w_grant;
    logic [1:0]            w_gidx;
    logic                  w_xfer;
    logic [REG_ADDR_W-1:0] w_sel_rd;
    logic [DATA_W-1:0]     w_sel_data;
    logic                  w_dispatch;
    logic [NREG-1:0]       w_busy_next;

    assign w_valid = {mul_valid, ld_valid, alu_valid};

    // Search order starting at the round-robin pointer
    always_comb begin
        w_o0 = 2'd0;
        w_o1 = 2'd1;
        w_o2 = 2'd2;
        case (r_rr)
            2'd1: begin
                w_o0 = 2'd1;
                w_o1 = 2'd2;
                w_o2 = 2'd0;
            end
            2'd2: begin
                w_o0 = 2'd2;
                w_o1 = 2'd0;
                w_o2 = 2'd1;
            end
            default: begin
                w_o0 = 2'd0;
                w_o1 = 2'd1;
                w_o2 = 2'd2;
            end
        endcase
    end

    // First valid source in search order wins; nothing is granted during reset
    always_comb begin
        w_grant = 3'b000;
        w_gidx  = 2'd0;
        if (!reset) begin
            if (w_valid[w_o0]) begin
                w_grant[w_o0] = 1'b1;
                w_gidx        = w_o0;
            end else if (w_valid[w_o1]) begin
                w_grant[w_o1] = 1'b1;
                w_gidx        = w_o1;
            end else if (w_valid[w_o2]) begin
                w_grant[w_o2] = 1'b1;
                w_gidx        = w_o2;
            end
        end
    end

    assign w_xfer    = |w_grant;
    assign alu_ready = w_grant[0];
    assign ld_ready  = w_grant[1];
    assign mul_ready = w_grant[2];

    // Mux the granted source's destination and value
    always_comb begin
        w_sel_rd   = alu_rd;
        w_sel_data = alu_data;
        case (w_gidx)
            2'd1: begin
                w_sel_rd   = ld_rd;
                w_sel_data = ld_data;
            end
            2'd2: begin
                w_sel_rd   = mul_rd;
                w_sel_data = mul_data;
            end
            default: begin
                w_sel_rd   = alu_rd;
                w_sel_data = alu_data;
            end
        endcase
    end

    // Reset forces iss_ready high even though the mask may not be cleared yet
    assign iss_ready  = reset | ~r_busy[iss_rd];
    assign w_dispatch = iss_valid & iss_ready;

    // Clear applied first so a same-register dispatch at the same edge keeps the bit set
    always_comb begin
        w_busy_next = r_busy;
        if (r_we) begin
            w_busy_next[r_wreg] = 1'b0;
        end
        if (w_dispatch) begin
            w_busy_next[iss_rd] = 1'b1;
        end
    end

    // Write-port registers and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_wreg  <= '0;
            r_wdata <= '0;
            r_rr    <= 2'd0;
        end else begin
            r_we <= w_xfer;
            if (w_xfer) begin
                r_wreg  <= w_sel_rd;
                r_wdata <= w_sel_data;
                r_rr    <= (w_gidx == 2'd2) ? 2'd0 : w_gidx + 2'd1;
            end
        end
    end

    // Pending-write mask
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign Write_enable = r_we;
    assign Write_reg    = r_wreg;
    assign Write_data   = r_wdata;
    assign busy         = r_busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, ld_valid, mul_valid;
    logic [3:0]  alu_rd, ld_rd, mul_rd;
    logic [15:0] alu_data, ld_data, mul_data;
    logic        alu_ready, ld_ready, mul_ready;
    logic        iss_valid;
    logic [3:0]  iss_rd;
    logic        iss_ready;
    logic        Write_enable;
    logic [3:0]  Write_reg;
    logic [15:0] Write_data;
    logic [15:0] busy;

    int tests = 0;
    int fails = 0;

    logic [19:0] exp_q[$];
    logic        pend   = 1'b0;
    logic        exp_we = 1'b0;

    regfile_wb_arbiter #(.DATA_W(16), .REG_ADDR_W(4)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .mul_valid(mul_valid), .mul_rd(mul_rd), .mul_data(mul_data), .mul_ready(mul_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .Write_enable(Write_enable), .Write_reg(Write_reg), .Write_data(Write_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // A grant pushed in this cycle becomes an expected Write_enable pulse in the next
    always @(posedge clk) begin
        exp_we = pend;
        pend   = 1'b0;
    end

    // Monitor: checks pulse timing and pops the expected write on every pulse
    always @(negedge clk) begin
        logic [19:0] e;
        tests++;
        if (Write_enable !== exp_we) begin
            fails++;
            $display("FAIL we_timing @%0t: got %b expected %b", $time, Write_enable, exp_we);
        end
        if (Write_enable === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got reg %0d data 0x%0h expected none", Write_reg, Write_data);
            end else begin
                e = exp_q.pop_front();
                if ({Write_reg, Write_data} !== e) begin
                    fails++;
                    $display("FAIL write: got reg %0d data 0x%0h expected reg %0d data 0x%0h",
                             Write_reg, Write_data, e[19:16], e[15:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // src: 0=ALU 1=LD 2=MUL, 3=none
    task automatic expect_grant(input int src, input logic [3:0] rd, input logic [15:0] data);
        logic [2:0] oh;
        oh = (src < 3) ? (3'b001 << src) : 3'b000;
        chk("readies", {29'd0, mul_ready, ld_ready, alu_ready}, {29'd0, oh});
        if (src < 3) begin
            exp_q.push_back({rd, data});
            pend = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b1;
        alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 16'h1111;
        ld_valid  = 1'b1; ld_rd  = 4'd2; ld_data  = 16'h2222;
        mul_valid = 1'b1; mul_rd = 4'd3; mul_data = 16'h3333;
        iss_valid = 1'b0; iss_rd = 4'd0;

        // Reset with all sources valid
        step();
        step();
        expect_grant(3, 4'd0, 16'h0);
        chk("rst_we", {31'd0, Write_enable}, 32'd0);
        chk("rst_busy", {16'd0, busy}, 32'h0);
        chk("rst_iss_ready", {31'd0, iss_ready}, 32'd1);

        // Round-robin with all three valid: ALU, LD, MUL, ALU, LD, MUL
        reset = 1'b0;
        settle();
        for (int i = 0; i < 6; i++) begin
            case (i % 3)
                0: expect_grant(0, 4'd1, 16'h1111);
                1: expect_grant(1, 4'd2, 16'h2222);
                default: expect_grant(2, 4'd3, 16'h3333);
            endcase
            step();
        end

        // Fairness skip with rr back at ALU: LD, MUL, LD
        alu_valid = 1'b0;
        settle();
        expect_grant(1, 4'd2, 16'h2222);
        step();
        expect_grant(2, 4'd3, 16'h3333);
        step();
        expect_grant(1, 4'd2, 16'h2222);
        step();
        ld_valid = 1'b0; mul_valid = 1'b0;
        settle();
        expect_grant(3, 4'd0, 16'h0);

        // Scoreboard: dispatch r5, then ALU writes r5
        iss_valid = 1'b1; iss_rd = 4'd5;
        settle();
        chk("iss_ready_r5_free", {31'd0, iss_ready}, 32'd1);
        step();
        iss_valid = 1'b0;
        settle();
        chk("busy_after_dispatch5", {16'd0, busy}, 32'h0020);
        chk("iss_ready_r5_busy", {31'd0, iss_ready}, 32'd0);
        alu_valid = 1'b1; alu_rd = 4'd5; alu_data = 16'hBEEF;
        settle();
        expect_grant(0, 4'd5, 16'hBEEF);
        step();
        alu_valid = 1'b0;
        settle();
        chk("busy5_during_we", {16'd0, busy}, 32'h0020);
        chk("iss_ready_r5_during_we", {31'd0, iss_ready}, 32'd0);
        step();
        chk("busy5_cleared", {16'd0, busy}, 32'h0000);
        chk("iss_ready_r5_after", {31'd0, iss_ready}, 32'd1);

        // Simultaneous set/clear on r7
        iss_valid = 1'b1; iss_rd = 4'd7;
        settle();
        step();
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 4'd7; alu_data = 16'h0707;
        settle();
        chk("busy7_set", {16'd0, busy}, 32'h0080);
        expect_grant(0, 4'd7, 16'h0707);
        step();
        alu_valid = 1'b0;
        ld_valid = 1'b1; ld_rd = 4'd7; ld_data = 16'h7777;
        settle();
        expect_grant(1, 4'd7, 16'h7777);
        step();
        ld_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 4'd7;
        settle();
        chk("busy7_cleared_prev", {16'd0, busy}, 32'h0000);
        chk("iss_ready_r7", {31'd0, iss_ready}, 32'd1);
        step();
        iss_valid = 1'b0;
        settle();
        chk("busy7_set_wins", {16'd0, busy}, 32'h0080);

        // Mid-flight reset
        mul_valid = 1'b1; mul_rd = 4'd3; mul_data = 16'h3333;
        iss_valid = 1'b1; iss_rd = 4'd9;
        settle();
        expect_grant(2, 4'd3, 16'h3333);
        step();
        mul_valid = 1'b0;
        iss_valid = 1'b0; iss_rd = 4'd7;
        ld_valid = 1'b1; ld_rd = 4'd4; ld_data = 16'h4444;
        reset = 1'b1;
        settle();
        chk("busy_before_reset", {16'd0, busy}, 32'h0280);
        chk("iss_ready_in_reset", {31'd0, iss_ready}, 32'd1);
        expect_grant(3, 4'd0, 16'h0);
        step();
        chk("we_after_reset", {31'd0, Write_enable}, 32'd0);
        chk("busy_after_reset", {16'd0, busy}, 32'h0000);
        reset = 1'b0;
        settle();
        expect_grant(1, 4'd4, 16'h4444);
        step();
        ld_valid = 1'b0;
        step();
        step();
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
